// File: rtl/crc_engine.sv
// Streaming CRC engine: folds DATA_W message bits per accepted beat into a
// running CRC, then serialises the final CRC MSB-first on the output port.
module crc_engine #(
    parameter int unsigned      CRC_W   = 7,
    parameter logic [CRC_W-1:0] POLY    = 7'h09,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter int unsigned      DATA_W  = 1,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CRC_W-1:0]  crc,
    output logic              frame_done,
    output logic              crc_ok,
    output logic              err
);

    localparam int unsigned NB    = (CRC_W + DATA_W - 1) / DATA_W;
    localparam int unsigned SR_W  = NB * DATA_W;
    localparam int unsigned CNT_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } state_t;

    state_t             state, state_n;
    logic [CRC_W-1:0]   run, run_n;
    logic [CRC_W-1:0]   crc_n;
    logic [SR_W-1:0]    sr, sr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               in_ready_n;
    logic               out_valid_n;
    logic               frame_done_n;
    logic               crc_ok_n;
    logic               err_n;

    logic               accept_c;
    logic               load_c;
    logic [CRC_W-1:0]   base_c;
    logic [CRC_W-1:0]   step_c;

    // Applies DATA_W serial CRC steps, in_data MSB first.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c_in,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = d[i] ^ c[CRC_W-1];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    assign accept_c = in_valid & in_ready;
    // A first-flagged beat always restarts from the seed, even mid-frame.
    assign base_c   = (state == CALC && !in_first) ? run : INIT;
    assign step_c   = crc_step(base_c, in_data);
    assign load_c   = accept_c && in_last && (state == CALC || in_first);
    assign out_data = sr[SR_W-1 -: DATA_W];

    always_comb begin
        state_n      = state;
        run_n        = run;
        crc_n        = crc;
        sr_n         = sr;
        cnt_n        = cnt;
        crc_ok_n     = crc_ok;
        frame_done_n = 1'b0;
        err_n        = 1'b0;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (in_first) begin
                        run_n   = step_c;
                        state_n = CALC;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            CALC: begin
                if (accept_c) begin
                    run_n = step_c;
                end
            end
            SEND: begin
                if (out_ready) begin
                    sr_n = sr << DATA_W;
                    if (cnt == CNT_W'(NB - 1)) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Frame completion: publish result, left-justify it for serialisation.
        if (load_c) begin
            crc_n        = step_c;
            sr_n         = SR_W'(step_c) << (SR_W - CRC_W);
            cnt_n        = '0;
            frame_done_n = 1'b1;
            crc_ok_n     = (step_c == RESIDUE);
            state_n      = SEND;
        end

        in_ready_n  = (state_n != SEND);
        out_valid_n = (state_n == SEND);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            run        <= INIT;
            crc        <= INIT;
            sr         <= '0;
            cnt        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            run        <= run_n;
            crc        <= crc_n;
            sr         <= sr_n;
            cnt        <= cnt_n;
            in_ready   <= in_ready_n;
            out_valid  <= out_valid_n;
            frame_done <= frame_done_n;
            crc_ok     <= crc_ok_n;
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: byte-wide and bit-serial instances checked against
// directed vectors and a polynomial-division reference model.
module tb_crc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Byte-wide instance
    logic       v8, r8, f8, l8, ov8, ordy8, fd8, ok8, err8;
    logic [7:0] d8, od8;
    logic [6:0] crc8;

    // Bit-serial instance
    logic       v1, r1, f1, l1, ov1, ordy1, fd1, ok1, err1;
    logic [0:0] d1, od1;
    logic [6:0] crc1;

    crc_engine #(.DATA_W(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(r8), .in_data(d8), .in_first(f8), .in_last(l8),
        .out_valid(ov8), .out_ready(ordy8), .out_data(od8),
        .crc(crc8), .frame_done(fd8), .crc_ok(ok8), .err(err8)
    );

    crc_engine #(.DATA_W(1)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(v1), .in_ready(r1), .in_data(d1), .in_first(f1), .in_last(l1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
        .crc(crc1), .frame_done(fd1), .crc_ok(ok1), .err(err1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC as remainder of M(x)*x^7 modulo G(x)=x^7+x^3+1 (seed is zero).
    function automatic logic [6:0] model_crc(input logic [63:0] m, input int nbits);
        logic [127:0] v;
        logic [127:0] g;
        v = 128'(m) << 7;
        g = 128'(8'h89);
        for (int k = nbits + 6; k >= 7; k--)
            if (v[k]) v = v ^ (g << (k - 7));
        return v[6:0];
    endfunction

    task automatic frame8(input logic [63:0] m, input int nb, input bit gaps);
        for (int k = 0; k < nb; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            v8 = 1'b1;
            d8 = m[8*(nb-1-k) +: 8];
            f8 = (k == 0);
            l8 = (k == nb - 1);
            @(negedge clk);
            v8 = 1'b0; f8 = 1'b0; l8 = 1'b0;
        end
    endtask

    task automatic frame1(input logic [63:0] m, input int nbits, input bit gaps);
        for (int k = 0; k < nbits; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            v1 = 1'b1;
            d1 = m[nbits-1-k];
            f1 = (k == 0);
            l1 = (k == nbits - 1);
            @(negedge clk);
            v1 = 1'b0; f1 = 1'b0; l1 = 1'b0;
        end
    endtask

    task automatic drain8(input logic [7:0] exp, input bit rnd);
        int  w    = 0;
        bit  done = 1'b0;
        while (!done && w < 50) begin
            chk("u8 out_valid in SEND", 64'(ov8), 64'(1));
            chk("u8 out_data", 64'(od8), 64'(exp));
            chk("u8 in_ready in SEND", 64'(r8), 64'(0));
            ordy8 = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
            done  = ordy8;
            @(negedge clk);
            ordy8 = 1'b0;
            w++;
        end
        chk("u8 drain bound", 64'(done), 64'(1));
        chk("u8 out_valid after SEND", 64'(ov8), 64'(0));
        chk("u8 in_ready after SEND", 64'(r8), 64'(1));
        chk("u8 frame_done one pulse", 64'(fd8), 64'(0));
    endtask

    task automatic drain1(input logic [6:0] c, input bit rnd);
        for (int i = 6; i >= 0; i--) begin
            int w    = 0;
            bit done = 1'b0;
            while (!done && w < 50) begin
                chk("u1 out_valid in SEND", 64'(ov1), 64'(1));
                chk("u1 out_data bit", 64'(od1), 64'(c[i]));
                ordy1 = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
                done  = ordy1;
                @(negedge clk);
                ordy1 = 1'b0;
                w++;
            end
            chk("u1 drain bound", 64'(done), 64'(1));
        end
        chk("u1 out_valid after SEND", 64'(ov1), 64'(0));
        chk("u1 in_ready after SEND", 64'(r1), 64'(1));
    endtask

    typedef struct {
        logic [63:0] msg;
        int          nbytes;
        logic [6:0]  crc;
        logic [7:0]  beat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [63:0] m;
        logic [6:0]  e;
        int          n;

        vecs[0] = '{64'h40_0000_0000, 5, 7'h4A, 8'h94};
        vecs[1] = '{64'h51_0000_0000, 5, 7'h2A, 8'h54};
        vecs[2] = '{64'h01,           1, 7'h09, 8'h12};
        vecs[3] = '{64'h80,           1, 7'h41, 8'h82};

        rst = 1'b0;
        v8 = 0; f8 = 0; l8 = 0; d8 = '0; ordy8 = 0;
        v1 = 0; f1 = 0; l1 = 0; d1 = '0; ordy1 = 0;
        repeat (3) @(negedge clk);

        chk("reset u8 out_valid", 64'(ov8), 64'(0));
        chk("reset u8 crc", 64'(crc8), 64'(0));
        chk("reset u8 frame_done", 64'(fd8), 64'(0));
        chk("reset u8 crc_ok", 64'(ok8), 64'(0));
        chk("reset u8 err", 64'(err8), 64'(0));
        chk("reset u8 in_ready", 64'(r8), 64'(1));
        chk("reset u1 out_valid", 64'(ov1), 64'(0));
        chk("reset u1 crc", 64'(crc1), 64'(0));
        chk("reset u1 in_ready", 64'(r1), 64'(1));
        rst = 1'b1;

        // Directed byte-wide frames
        for (int i = 0; i < 4; i++) begin
            frame8(vecs[i].msg, vecs[i].nbytes, 1'b0);
            chk("u8 frame_done", 64'(fd8), 64'(1));
            chk("u8 crc", 64'(crc8), 64'(vecs[i].crc));
            chk("u8 crc_ok", 64'(ok8), 64'(vecs[i].crc == 7'h0));
            drain8(vecs[i].beat, 1'b0);
        end

        // Output backpressure for three cycles, input beats ignored meanwhile
        frame8(64'h40_0000_0000, 5, 1'b0);
        chk("bp crc", 64'(crc8), 64'(7'h4A));
        for (int c = 0; c < 3; c++) begin
            v8 = 1'b1; f8 = 1'b1; l8 = 1'b1; d8 = 8'hFF;
            chk("bp out_valid", 64'(ov8), 64'(1));
            chk("bp out_data", 64'(od8), 64'(8'h94));
            chk("bp in_ready", 64'(r8), 64'(0));
            @(negedge clk);
            chk("bp err", 64'(err8), 64'(0));
            chk("bp crc held", 64'(crc8), 64'(7'h4A));
        end
        v8 = 1'b0; f8 = 1'b0; l8 = 1'b0;
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        chk("bp out_valid after handshake", 64'(ov8), 64'(0));
        chk("bp in_ready after handshake", 64'(r8), 64'(1));

        // Restart mid-frame: result covers only the new frame
        v8 = 1'b1; f8 = 1'b1; d8 = 8'h12; @(negedge clk);
        f8 = 1'b0; d8 = 8'h34; @(negedge clk);
        v8 = 1'b0;
        frame8(64'h40_0000_0000, 5, 1'b0);
        chk("abort err", 64'(err8), 64'(0));
        chk("abort crc", 64'(crc8), 64'(7'h4A));
        drain8(8'h94, 1'b0);

        // Beat without first in IDLE is dropped with an error pulse
        v8 = 1'b1; d8 = 8'h55; l8 = 1'b1; @(negedge clk);
        v8 = 1'b0; l8 = 1'b0;
        chk("idle err pulse", 64'(err8), 64'(1));
        chk("idle err out_valid", 64'(ov8), 64'(0));
        chk("idle err frame_done", 64'(fd8), 64'(0));
        chk("idle err crc held", 64'(crc8), 64'(7'h4A));
        @(negedge clk);
        chk("idle err one pulse", 64'(err8), 64'(0));
        frame8(64'h01, 1, 1'b0);
        chk("after err crc", 64'(crc8), 64'(7'h09));
        drain8(8'h12, 1'b0);

        // Reset mid-frame
        v8 = 1'b1; f8 = 1'b1; d8 = 8'h40; @(negedge clk);
        f8 = 1'b0; d8 = 8'h00; @(negedge clk);
        v8 = 1'b0;
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        chk("rst mid-frame out_valid", 64'(ov8), 64'(0));
        chk("rst mid-frame crc", 64'(crc8), 64'(0));
        chk("rst mid-frame in_ready", 64'(r8), 64'(1));
        frame8(64'h40_0000_0000, 5, 1'b0);
        chk("after rst crc", 64'(crc8), 64'(7'h4A));
        chk("after rst frame_done", 64'(fd8), 64'(1));
        drain8(8'h94, 1'b0);

        // Reset mid-SEND
        frame8(64'h80, 1, 1'b0);
        chk("pre rst SEND out_valid", 64'(ov8), 64'(1));
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        chk("rst mid-SEND out_valid", 64'(ov8), 64'(0));
        chk("rst mid-SEND crc", 64'(crc8), 64'(0));
        chk("rst mid-SEND crc_ok", 64'(ok8), 64'(0));

        // Bit-serial frames
        frame1(64'h40_0000_0000, 40, 1'b0);
        chk("u1 frame_done", 64'(fd1), 64'(1));
        chk("u1 crc frame A", 64'(crc1), 64'(7'h4A));
        drain1(7'b1001010, 1'b0);
        frame1(64'h51_0000_0000, 40, 1'b0);
        chk("u1 crc frame B", 64'(crc1), 64'(7'h2A));
        drain1(7'h2A, 1'b0);

        // Check mode: message plus its CRC leaves a zero residue
        m = {17'h0, 40'h40_0000_0000, 7'b1001010};
        frame1(m, 47, 1'b0);
        chk("check crc", 64'(crc1), 64'(0));
        chk("check crc_ok", 64'(ok1), 64'(1));
        drain1(7'h0, 1'b0);
        m = m ^ (64'h1 << 20);
        frame1(m, 47, 1'b0);
        chk("check flipped crc_ok", 64'(ok1), 64'(0));
        chk("check flipped crc", 64'(crc1), 64'(model_crc(m, 47)));
        drain1(crc1, 1'b0);

        // Randomised frames against the division model
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 6);
            m = {$urandom, $urandom};
            m = m & ((64'h1 << (8 * n)) - 64'h1);
            e = model_crc(m, 8 * n);
            frame8(m, n, 1'b1);
            chk("rand u8 frame_done", 64'(fd8), 64'(1));
            chk("rand u8 crc", 64'(crc8), 64'(e));
            chk("rand u8 crc_ok", 64'(ok8), 64'(e == 7'h0));
            drain8({e, 1'b0}, 1'b1);
        end
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 40);
            m = {$urandom, $urandom};
            m = m & ((64'h1 << n) - 64'h1);
            e = model_crc(m, n);
            frame1(m, n, 1'b1);
            chk("rand u1 frame_done", 64'(fd1), 64'(1));
            chk("rand u1 crc", 64'(crc1), 64'(e));
            chk("rand u1 crc_ok", 64'(ok1), 64'(e == 7'h0));
            chk("rand u1 err", 64'(err1), 64'(0));
            drain1(e, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
